// File: rtl/keypad_time_entry.sv
// Keypad digit entry for an oven timer: shifts BCD digits into a 4-digit MM:SS buffer.
// Optional key debouncing is enabled by defining KEYPAD_DEBOUNCE_EN.
module keypad_time_entry #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  bcd_in,
    input  logic        valid_in,
    input  logic        load_en,
    input  logic        clear,
    input  logic        start,
    output logic [15:0] digits,
    output logic [2:0]  digit_count,
    output logic        key_strobe,
    output logic        time_ready,
    output logic        entry_error
);

    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("DEBOUNCE_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;
    logic       key_valid;
    logic       accept;
    logic [3:0] accept_code;

    // Codes above 9 are not digits and behave exactly like no key pressed.
    assign key_valid = valid_in && (bcd_in <= 4'd9);

`ifdef KEYPAD_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [3:0]    code_q;
    logic [3:0]    code_next;

    assign accept_code = (state == IDLE) ? bcd_in : code_q;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        code_next  = code_q;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (key_valid) begin
                    code_next = bcd_in;
                    if (DEBOUNCE_CYCLES <= 1) begin
                        accept     = 1'b1;
                        state_next = PRESSED;
                        cnt_next   = '0;
                    end else begin
                        state_next = PRESS_WAIT;
                        cnt_next   = CW'(1);
                    end
                end
            end
            PRESS_WAIT: begin
                // cnt holds the number of stable samples already seen.
                if (key_valid && (bcd_in == code_q)) begin
                    if (int'(cnt) + 1 >= DEBOUNCE_CYCLES) begin
                        accept     = 1'b1;
                        state_next = PRESSED;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt + CW'(1);
                    end
                end else begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            end
            PRESSED: begin
                if (!key_valid) begin
                    if (DEBOUNCE_CYCLES <= 1) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        state_next = RELEASE_WAIT;
                        cnt_next   = CW'(1);
                    end
                end
            end
            RELEASE_WAIT: begin
                if (key_valid) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (int'(cnt) + 1 >= DEBOUNCE_CYCLES) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            code_q <= 4'd0;
        end else begin
            cnt    <= cnt_next;
            code_q <= code_next;
        end
    end
`else
    assign accept_code = bcd_in;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (key_valid) begin
                    accept     = 1'b1;
                    state_next = PRESSED;
                end
            end
            PRESSED: begin
                if (!key_valid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Buffer and pulses: clear beats start beats digit accept; the FSM advances regardless.
    always_ff @(posedge clk) begin
        if (reset) begin
            digits      <= 16'h0000;
            digit_count <= 3'd0;
            key_strobe  <= 1'b0;
            time_ready  <= 1'b0;
            entry_error <= 1'b0;
        end else begin
            key_strobe  <= 1'b0;
            time_ready  <= 1'b0;
            entry_error <= 1'b0;
            if (clear) begin
                digits      <= 16'h0000;
                digit_count <= 3'd0;
            end else if (start) begin
                if (digit_count != 3'd0) begin
                    if (digits[7:4] > 4'd5) entry_error <= 1'b1;
                    else                    time_ready  <= 1'b1;
                end
            end else if (accept && load_en && (digit_count < 3'd4)) begin
                digits      <= {digits[11:0], accept_code};
                digit_count <= digit_count + 3'd1;
                key_strobe  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_keypad_time_entry.sv
// Self-checking bench for keypad_time_entry; follows KEYPAD_DEBOUNCE_EN like the design.
module tb_keypad_time_entry;

    localparam int DB = 4;
`ifdef KEYPAD_DEBOUNCE_EN
    localparam int ON = 1;
`else
    localparam int ON = 0;
`endif
    localparam int HI = (ON != 0) ? DB + 2 : 3;
    localparam int LO = (ON != 0) ? DB + 2 : 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  bcd_in = 4'd0;
    logic        valid_in = 1'b0;
    logic        load_en = 1'b1;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [15:0] digits;
    logic [2:0]  digit_count;
    logic        key_strobe;
    logic        time_ready;
    logic        entry_error;

    keypad_time_entry #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk         (clk),
        .reset       (reset),
        .bcd_in      (bcd_in),
        .valid_in    (valid_in),
        .load_en     (load_en),
        .clear       (clear),
        .start       (start),
        .digits      (digits),
        .digit_count (digit_count),
        .key_strobe  (key_strobe),
        .time_ready  (time_ready),
        .entry_error (entry_error)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass = 0;
    int n_strobes = 0;
    int n_ready = 0;
    int n_err = 0;

    // Reference model: the entry buffer as a digit list plus a notion of "key is down".
    logic [15:0] m_digits = 16'h0;
    logic [2:0]  m_count = 3'd0;
    logic        m_str = 1'b0;
    logic        m_rdy = 1'b0;
    logic        m_err = 1'b0;
    bit          m_held = 1'b0;
    bit          m_pressed = 1'b0;
    int          m_run = 0;
    int          m_rel = 0;
    logic [3:0]  m_code = 4'd0;

    logic [21:0] exp_q[$];

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic model_step();
        bit kv;
        bit acc;
        kv  = valid_in && (bcd_in <= 4'd9);
        acc = 1'b0;
        if (reset) begin
            m_digits = 16'h0; m_count = 3'd0;
            m_str = 1'b0; m_rdy = 1'b0; m_err = 1'b0;
            m_held = 1'b0; m_pressed = 1'b0; m_run = 0; m_rel = 0;
            return;
        end
        if (ON != 0) begin
            // A press counts after DB identical samples; a release after DB empty samples.
            if (!m_pressed) begin
                if (kv && m_run > 0 && bcd_in == m_code) m_run++;
                else if (kv && m_run == 0) begin m_run = 1; m_code = bcd_in; end
                else m_run = 0;
                if (m_run >= DB) begin acc = 1'b1; m_pressed = 1'b1; m_run = 0; m_rel = 0; end
            end else begin
                if (kv) m_rel = 0;
                else m_rel++;
                if (m_rel >= DB) begin m_pressed = 1'b0; m_rel = 0; end
            end
        end else begin
            acc = kv && !m_held;
            m_code = bcd_in;
            m_held = kv;
        end
        m_str = 1'b0; m_rdy = 1'b0; m_err = 1'b0;
        if (clear) begin
            m_digits = 16'h0; m_count = 3'd0;
        end else if (start) begin
            if (m_count != 0) begin
                if (m_digits[7:4] > 5) m_err = 1'b1;
                else m_rdy = 1'b1;
            end
        end else if (acc && load_en && m_count < 4) begin
            m_digits = (m_digits << 4) | {12'h0, m_code};
            m_count  = m_count + 3'd1;
            m_str    = 1'b1;
        end
    endtask

    task automatic cycle();
        logic [21:0] e;
        @(posedge clk);
        model_step();
        exp_q.push_back({m_digits, m_count, m_str, m_rdy, m_err});
        #1;
        e = exp_q.pop_front();
        check("digits", digits, e[21:6]);
        check("digit_count", 16'(digit_count), 16'(e[5:3]));
        check("key_strobe", 16'(key_strobe), 16'(e[2]));
        check("time_ready", 16'(time_ready), 16'(e[1]));
        check("entry_error", 16'(entry_error), 16'(e[0]));
        check("exclusive", 16'($countones({key_strobe, time_ready, entry_error}) > 1), 16'd0);
        if (key_strobe) n_strobes++;
        if (time_ready) n_ready++;
        if (entry_error) n_err++;
    endtask

    task automatic press(input logic [3:0] code, input int hi, input int lo);
        valid_in = 1'b1; bcd_in = code;
        repeat (hi) cycle();
        valid_in = 1'b0;
        repeat (lo) cycle();
    endtask

    task automatic pulse_start();
        start = 1'b1; cycle(); start = 1'b0; cycle();
    endtask

    task automatic pulse_clear();
        clear = 1'b1; cycle(); clear = 1'b0; cycle();
    endtask

    initial begin
        reset = 1'b1;
        repeat (2) cycle();
        check("reset_digits", digits, 16'h0000);
        check("reset_count", 16'(digit_count), 16'd0);
        reset = 1'b0;
        cycle();

        if (ON != 0) begin
            n_strobes = 0;
            press(4'd5, DB - 1, LO);
            check("short_press_count", 16'(digit_count), 16'd0);
            press(4'd5, DB + 2, LO);
            check("debounced_digits", digits, 16'h0005);
            check("debounced_strobes", 16'(n_strobes), 16'd1);
            pulse_clear();
        end

        n_strobes = 0;
        press(4'd1, HI, LO);
        press(4'd2, HI, LO);
        press(4'd3, HI, LO);
        press(4'd0, HI, LO);
        check("four_digits", digits, 16'h1230);
        check("four_count", 16'(digit_count), 16'd4);
        check("four_strobes", 16'(n_strobes), 16'd4);

        n_strobes = 0; n_ready = 0;
        press(4'd7, HI, LO);
        check("fifth_digits", digits, 16'h1230);
        check("fifth_strobes", 16'(n_strobes), 16'd0);
        pulse_start();
        check("ready_pulses", 16'(n_ready), 16'd1);

        pulse_clear();
        n_err = 0; n_ready = 0;
        press(4'd0, HI, LO);
        press(4'd7, HI, LO);
        press(4'd5, HI, LO);
        pulse_start();
        check("error_pulses", 16'(n_err), 16'd1);
        check("error_ready", 16'(n_ready), 16'd0);
        check("error_kept", digits, 16'h0075);
        pulse_clear();
        check("clear_digits", digits, 16'h0000);
        check("clear_count", 16'(digit_count), 16'd0);

        press(4'd9, HI, LO);
        n_strobes = 0;
        valid_in = 1'b1; bcd_in = 4'd4;
        repeat ((ON != 0) ? DB - 1 : 0) cycle();
        clear = 1'b1; cycle(); clear = 1'b0;
        repeat (HI + 2) cycle();
        valid_in = 1'b0;
        repeat (LO) cycle();
        check("clear_press_digits", digits, 16'h0000);
        check("clear_press_strobes", 16'(n_strobes), 16'd0);

        n_strobes = 0;
        load_en = 1'b0;
        press(4'd8, HI, LO);
        load_en = 1'b1;
        check("locked_strobes", 16'(n_strobes), 16'd0);
        check("locked_count", 16'(digit_count), 16'd0);

        press(4'd3, HI, LO);
        valid_in = 1'b1; bcd_in = 4'd6;
        repeat (2) cycle();
        reset = 1'b1; cycle();
        check("midpress_reset_digits", digits, 16'h0000);
        check("midpress_reset_count", 16'(digit_count), 16'd0);
        check("midpress_reset_strobe", 16'(key_strobe), 16'd0);
        reset = 1'b0;
        n_strobes = 0;
        repeat (HI + 2) cycle();
        valid_in = 1'b0;
        repeat (LO) cycle();
        check("held_after_reset_digits", digits, 16'h0006);
        check("held_after_reset_strobes", 16'(n_strobes), 16'd1);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                valid_in = ($urandom_range(0, 9) < 6);
                bcd_in   = 4'($urandom_range(0, 11));
            end
            load_en = ($urandom_range(0, 9) != 0);
            clear   = ($urandom_range(0, 39) == 0);
            start   = ($urandom_range(0, 19) == 0);
            reset   = ($urandom_range(0, 149) == 0);
            cycle();
        end
        reset = 1'b0; clear = 1'b0; start = 1'b0; valid_in = 1'b0;
        cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/keypad_time_entry.md
KEYPAD_TIME_ENTRY -- requirements
Module: keypad_time_entry

Interface
REQ-001 SHALL have parameter: DEBOUNCE_CYCLES, 4, consecutive stable cycles needed to accept a press or release (used only with KEYPAD_DEBOUNCE_EN).
REQ-002 SHALL have ports, one clock, synchronous active-high reset:
- clk  input  1  rising-edge system clock
- reset  input  1  synchronous, active-high reset
- bcd_in  input  4  digit code from upstream priority encoder
- valid_in  input  1  high while exactly one key is pressed
- load_en  input  1  high = digit entry allowed (low while oven running)
- clear  input  1  synchronous entry-buffer clear, one-cycle request
- start  input  1  request to commit entered time, one-cycle request
- digits  output  16  entry buffer {min_tens, min_ones, sec_tens, sec_ones}, BCD
- digit_count  output  3  number of digits entered, 0..4
- key_strobe  output  1  one-cycle pulse per accepted digit
- time_ready  output  1  one-cycle pulse: digits valid committed time
- entry_error  output  1  one-cycle pulse: start rejected, sec_tens > 5

Function
REQ-003 SHALL use FSM states IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT; all outputs registered.
REQ-004 IDLE: valid_in=1 -> PRESS_WAIT (debounce on) or accept digit and -> PRESSED (debounce off).
REQ-005 PRESS_WAIT: counter increments while valid_in=1 and bcd_in equals the code captured on entry; on DEBOUNCE_CYCLES reached -> accept, PRESSED; valid_in=0 or code change -> IDLE, no accept.
REQ-006 PRESSED: valid_in=0 -> RELEASE_WAIT (debounce on) or IDLE (debounce off); held key never re-accepted.
REQ-007 RELEASE_WAIT: valid_in=0 for DEBOUNCE_CYCLES consecutive cycles -> IDLE; any valid_in=1 -> PRESSED, counter cleared.
REQ-008 Accept with load_en=1 and digit_count<4: digits <= {digits[11:0], code}, digit_count+1, key_strobe=1 the following cycle only.
REQ-009 Accept with load_en=0 or digit_count=4: buffer and count unchanged, no key_strobe; FSM still advances to PRESSED.
REQ-010 Debounce off latency: valid_in sampled high at edge k in IDLE -> digits/digit_count/key_strobe updated at edge k.
REQ-011 bcd_in values >9 SHALL be ignored (treated as valid_in=0).
REQ-012 start with digit_count=0: no pulse; sec_tens>5: entry_error=1 one cycle; else time_ready=1 one cycle; buffer retained in all cases.
REQ-013 clear: digits=0, digit_count=0 at next edge; FSM unaffected.
REQ-014 Same-cycle priority: clear > start > digit accept; a press coinciding with clear or start is consumed (FSM -> PRESSED) without shifting.
REQ-015 key_strobe, time_ready, entry_error SHALL never be high simultaneously.

Reset
REQ-016 reset=1 at a rising edge: state=IDLE, debounce counter=0, digits=16'h0000, digit_count=0, key_strobe=0, time_ready=0, entry_error=0.
REQ-017 reset SHALL override all inputs, including mid-debounce and mid-press; a key still held after reset is accepted once as a new press.

Configuration
REQ-018 Macro KEYPAD_DEBOUNCE_EN defined: PRESS_WAIT/RELEASE_WAIT and counter present, acceptance after DEBOUNCE_CYCLES stable cycles.
REQ-019 Macro KEYPAD_DEBOUNCE_EN undefined: wait states and counter omitted, transitions per REQ-004/REQ-006/REQ-010, DEBOUNCE_CYCLES ignored.

Verification
REQ-020 Debounce off: press 1,2,3,0 (each valid_in 3 cycles, 2 cycles low) -> digits=16'h1230, digit_count=4, four key_strobe pulses.
REQ-021 Fifth key 7 after REQ-020 -> digits stays 16'h1230, no key_strobe; start -> time_ready one cycle.
REQ-022 Debounce on, DEBOUNCE_CYCLES=4: valid_in high 3 cycles then low -> no accept; high 6 cycles with bcd_in=5 -> digits=16'h0005, one strobe.
REQ-023 Enter 0,7,5 then start -> entry_error one cycle (sec_tens=7), buffer 16'h0075 kept; clear -> digits=0, digit_count=0.
REQ-024 clear and key press same cycle -> buffer 0, no strobe, no accept on continued hold; reset asserted during PRESS_WAIT -> all outputs 0, state IDLE.
